midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Schedules note events from two requesters, the SPI MIDI path and the local tracker, onto the `CHANNELS` ADPCM playback voices. It arbitrates between the requesters and tracks which voice plays which note. It then emits one-cycle `key_on`/`key_off` strobes with `note`/`octave` toward the voice engine, and status strobes toward the SPI MIDI status encoder. When all voices are busy it steals the oldest voice (configurable), and it frees voices when the engine reports sample end.

## Interface
- `CHANNELS`, default 3: number of voices, 1..8.
- `AGE_WIDTH`, default 4: width of each per-voice age counter.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high; clock `clk`.
- `req_valid`  in  2  request valid; bit 0 = SPI MIDI, bit 1 = tracker.
- `req_ready`  out  2  per-requester ready; a handshake is `valid & ready` at a rising edge.
- `req_note_on`  in  2  1 = note on, 0 = note off, per requester.
- `req_note`  in  8  4 bits per requester, [3:0] = requester 0.
- `req_octave`  in  4  2 bits per requester.
- `voice_done`  in  CHANNELS  voice finished its sample; frees that voice.
- `key_on`, `key_off`  out  CHANNELS  one-cycle strobes; at most one bit set, never both.
- `note`  out  4  note of the last issued event; holds between events.
- `octave`  out  2  octave of the last issued event; holds between events.
- `status_valid`  out  1  one-cycle strobe.
- `status_note_on`  out  1  status event type.
- `status_note`  out  4  status note.
- `status_octave`  out  2  status octave.
- `status_channel`  out  4  voice index of the status event.
- `drop`  out  1  one-cycle strobe: note on discarded.

## Operation
- Per-voice state: `busy`, `note` (4 bits), `octave` (2 bits), `age` (AGE_WIDTH bits).
- States: IDLE → LOOKUP → ISSUE → IDLE, unconditional except at IDLE.
  - IDLE: `req_ready` is nonzero. Arbitration is round-robin: if both requesters are valid, grant the one not granted last. The `last` pointer resets to 1, so requester 0 wins the first tie. Only the granted bit of `req_ready` is high; if neither is valid, `req_ready` = 2'b01 when `last` is 1, otherwise 2'b10. A handshake latches the event and moves to LOOKUP.
  - LOOKUP: choose the target voice. The ISSUE-stage output registers load at the end of LOOKUP.
  - ISSUE: strobes are high for this single cycle, and voice state updates at its end.
- Note-on target, in priority order:
  1. Busy voice with matching note and octave (retrigger). Lowest index wins.
  2. Lowest-index free voice.
  3. Steal: busy voice with the largest `age`, ties to the lowest index.
- Note-on result: set `key_on` for the target. Load the target's note/octave, set `busy`, and clear its `age`. Increment every other busy voice's `age`, saturating at all-ones. Emit status with `status_note_on` = 1.
- Note-off: target is the lowest-index busy voice with matching note and octave. Set `key_off`, clear `busy`, and emit status with `status_note_on` = 0. With no match, nothing is strobed; the handshake still completes.
- `voice_done[i]` clears `busy[i]` in any state. It is ignored if voice i is not busy.
- Simultaneous `voice_done[i]` and an ISSUE-cycle note on to voice i: the allocation wins and `busy` stays 1. With the same timing and a note off to voice i, the voice ends not busy.
- LOOKUP uses `busy` as registered at LOOKUP entry. A voice freed during LOOKUP is not visible until the next event.
- Reset, including mid-operation: state IDLE, all voices free with age 0, `last` = 1. Any in-flight event is lost.
- Output reset values: all strobes 0 (`key_on`, `key_off`, `status_valid`, `drop`); `note`, `octave`, `status_*` = 0; `req_ready` = 2'b01.

## Timing
- Handshake at the edge ending cycle N.
- LOOKUP occupies cycle N+1.
- `key_on`/`key_off`, `status_*` and `drop` are high only in cycle N+2; `note`/`octave` are valid from N+2 and hold until the next event.
- `req_ready` is 2'b00 in cycles N+1 and N+2 and returns in N+3.
- Sustained throughput: one event per 3 cycles.
- All outputs are registered; there is no combinational path from the `req_*` inputs to `key_*`. `req_ready` is a function of state and `last` only.

## Configuration
- `VOICE_STEAL_EN` defined: step 3 (steal) is active as described.
- `VOICE_STEAL_EN` undefined: a note on with no retrigger match and no free voice produces no `key_on` and no status. It pulses `drop` in cycle N+2 and leaves voice state and ages unchanged. `drop` is held 0 when the macro is defined.

## Structure
- Package `midi_voice_pkg` holds:
  - state enum `voice_alloc_state_t`;
  - requester constants `REQ_SPI` = 0 and `REQ_TRACKER` = 1;
  - `AGE_MAX` (the age saturation value);
  - per-voice struct `voice_slot_t` (busy, note, octave, age).
- Sub-module `voice_select`: combinational target finder. It takes the slot array and the event, and outputs the target index, `found`, and `stolen`.

## Test plan
1. Reset, then SPI note on 4/1 → `key_on` = 3'b001 in cycle N+2 with `note` = 4, `octave` = 1; status channel 0 with `status_note_on` = 1.
2. Both requesters valid with note on 1/0 and note on 2/0 → SPI is served first on voice 0 and the tracker three cycles later on voice 1; after that, a tie goes to SPI first.
3. Three note ons fill voices 0..2, then a fourth note on 7/2:
   - with `VOICE_STEAL_EN`: `key_on` = 3'b001, because voice 0 is oldest;
   - without it: `drop` = 1, `key_on` = 0.
4. Note on 5/0 twice → the second strobes `key_on` on the same voice (retrigger), and no second voice is used.
5. Note off 5/0 with no voice playing it → no strobe, `req_ready` returns in cycle N+3. Note off of a playing note → `key_off` on its voice, status with `status_note_on` = 0.
6. `voice_done[1]` in the same cycle as an ISSUE note on to voice 1 → voice 1 stays busy, and the next note on goes to another free voice. Asserting `reset` during LOOKUP → no strobes, all voices free.

Source files
------------

// File: rtl/midi_voice_pkg.sv
// Shared types and constants for the MIDI voice allocator.
package midi_voice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE
    } voice_alloc_state_t;

    localparam int unsigned REQ_SPI     = 0;
    localparam int unsigned REQ_TRACKER = 1;

    // Age storage is sized for the widest supported AGE_WIDTH (8).
    localparam int unsigned AGE_W_MAX = 8;
    localparam int unsigned IDX_W     = 3;

    typedef struct packed {
        logic                 busy;
        logic [3:0]           note;
        logic [1:0]           octave;
        logic [AGE_W_MAX-1:0] age;
    } voice_slot_t;

    // Saturation value of an age counter that is w bits wide.
    function automatic logic [AGE_W_MAX-1:0] AGE_MAX(input int unsigned w);
        return AGE_W_MAX'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational target finder: retrigger match, then free voice, then steal.
// Stealing the oldest voice is compiled in only with VOICE_STEAL_EN.
module voice_select
    import midi_voice_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  voice_slot_t [CHANNELS-1:0] slots_i,
    input  logic                       note_on_i,
    input  logic [3:0]                 note_i,
    input  logic [1:0]                 octave_i,
    output logic [IDX_W-1:0]           idx_o,
    output logic                       found_o,
    output logic                       stolen_o
);

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             free;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (slots_i[i].busy && !hit &&
                slots_i[i].note == note_i &&
                slots_i[i].octave == octave_i) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slots_i[i].busy && !free) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic                 old_hit;
    logic [IDX_W-1:0]     old_idx;
    logic [AGE_W_MAX-1:0] old_age;

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        old_hit = 1'b0;
        old_idx = '0;
        old_age = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (slots_i[i].busy &&
                (!old_hit || slots_i[i].age > old_age)) begin
                old_hit = 1'b1;
                old_idx = IDX_W'(i);
                old_age = slots_i[i].age;
            end
        end
    end
`endif

    always_comb begin
        idx_o    = hit_idx;
        found_o  = hit;
        stolen_o = 1'b0;
        if (!hit && note_on_i) begin
            if (free) begin
                idx_o   = free_idx;
                found_o = 1'b1;
            end
`ifdef VOICE_STEAL_EN
            else if (old_hit) begin
                idx_o    = old_idx;
                stolen_o = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Arbitrates SPI MIDI / tracker note events onto playback voices.
// VOICE_STEAL_EN: steal the oldest voice when none is free, else drop.
module midi_voice_allocator
    import midi_voice_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int AGE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_note_on,
    input  logic [7:0]          req_note,
    input  logic [3:0]          req_octave,
    input  logic [CHANNELS-1:0] voice_done,
    output logic [CHANNELS-1:0] key_on,
    output logic [CHANNELS-1:0] key_off,
    output logic [3:0]          note,
    output logic [1:0]          octave,
    output logic                status_valid,
    output logic                status_note_on,
    output logic [3:0]          status_note,
    output logic [1:0]          status_octave,
    output logic [3:0]          status_channel,
    output logic                drop
);

    localparam logic [AGE_W_MAX-1:0] AGE_SAT = AGE_MAX(AGE_WIDTH);

    voice_alloc_state_t state_q, state_d;
    logic                        last_q, last_d;
    voice_slot_t [CHANNELS-1:0]  slot_q, slot_d;
    logic                        ev_on_q, ev_on_d;
    logic [3:0]                  ev_note_q, ev_note_d;
    logic [1:0]                  ev_oct_q, ev_oct_d;
    logic [IDX_W-1:0]            tgt_q, tgt_d;

    logic [CHANNELS-1:0] key_on_q, key_on_d;
    logic [CHANNELS-1:0] key_off_q, key_off_d;
    logic [3:0]          note_q, note_d;
    logic [1:0]          octave_q, octave_d;
    logic                st_valid_q, st_valid_d;
    logic                st_on_q, st_on_d;
    logic [3:0]          st_note_q, st_note_d;
    logic [1:0]          st_oct_q, st_oct_d;
    logic [3:0]          st_ch_q, st_ch_d;
    logic                drop_q, drop_d;

    logic             grant;
    logic             hs;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             sel_stolen;
    logic             sel_hit;
    logic             issue_on;
    logic             issue_off;

    voice_select #(
        .CHANNELS (CHANNELS)
    ) u_select (
        .slots_i   (slot_q),
        .note_on_i (ev_on_q),
        .note_i    (ev_note_q),
        .octave_i  (ev_oct_q),
        .idx_o     (sel_idx),
        .found_o   (sel_found),
        .stolen_o  (sel_stolen)
    );

    assign sel_hit   = sel_found | sel_stolen;
    assign issue_on  = (state_q == ST_ISSUE) && (|key_on_q);
    assign issue_off = (state_q == ST_ISSUE) && (|key_off_q);

    // Round-robin: on a tie (or no request) point at the one not granted last.
    always_comb begin
        grant = ~last_q;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end
        req_ready = 2'b00;
        if (state_q == ST_IDLE) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        hs = (state_q == ST_IDLE) && req_valid[grant];
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ev_on_d    = ev_on_q;
        ev_note_d  = ev_note_q;
        ev_oct_d   = ev_oct_q;
        tgt_d      = tgt_q;
        key_on_d   = '0;
        key_off_d  = '0;
        st_valid_d = 1'b0;
        drop_d     = 1'b0;
        note_d     = note_q;
        octave_d   = octave_q;
        st_on_d    = st_on_q;
        st_note_d  = st_note_q;
        st_oct_d   = st_oct_q;
        st_ch_d    = st_ch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_LOOKUP;
                    last_d    = grant;
                    ev_on_d   = req_note_on[grant];
                    ev_note_d = grant ? req_note[7:4] : req_note[3:0];
                    ev_oct_d  = grant ? req_octave[3:2] : req_octave[1:0];
                end
            end
            ST_LOOKUP: begin
                state_d = ST_ISSUE;
                tgt_d   = sel_idx;
                if (sel_hit) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        key_on_d[i]  = ev_on_q && (IDX_W'(i) == sel_idx);
                        key_off_d[i] = !ev_on_q && (IDX_W'(i) == sel_idx);
                    end
                    note_d     = ev_note_q;
                    octave_d   = ev_oct_q;
                    st_valid_d = 1'b1;
                    st_on_d    = ev_on_q;
                    st_note_d  = ev_note_q;
                    st_oct_d   = ev_oct_q;
                    st_ch_d    = 4'(sel_idx);
                end
`ifndef VOICE_STEAL_EN
                drop_d = ev_on_q && !sel_hit;
`endif
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // voice_done frees first; a same-cycle note on re-claims the voice.
    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (voice_done[i]) begin
                slot_d[i].busy = 1'b0;
            end
            if (issue_on) begin
                if (IDX_W'(i) == tgt_q) begin
                    slot_d[i].busy   = 1'b1;
                    slot_d[i].note   = ev_note_q;
                    slot_d[i].octave = ev_oct_q;
                    slot_d[i].age    = '0;
                end else if (slot_q[i].busy && slot_q[i].age != AGE_SAT) begin
                    slot_d[i].age = slot_q[i].age + 1'b1;
                end
            end
            if (issue_off && IDX_W'(i) == tgt_q) begin
                slot_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            slot_q     <= '0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            ev_oct_q   <= '0;
            tgt_q      <= '0;
            key_on_q   <= '0;
            key_off_q  <= '0;
            note_q     <= '0;
            octave_q   <= '0;
            st_valid_q <= 1'b0;
            st_on_q    <= 1'b0;
            st_note_q  <= '0;
            st_oct_q   <= '0;
            st_ch_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            slot_q     <= slot_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            ev_oct_q   <= ev_oct_d;
            tgt_q      <= tgt_d;
            key_on_q   <= key_on_d;
            key_off_q  <= key_off_d;
            note_q     <= note_d;
            octave_q   <= octave_d;
            st_valid_q <= st_valid_d;
            st_on_q    <= st_on_d;
            st_note_q  <= st_note_d;
            st_oct_q   <= st_oct_d;
            st_ch_q    <= st_ch_d;
            drop_q     <= drop_d;
        end
    end

    assign key_on         = key_on_q;
    assign key_off        = key_off_q;
    assign note           = note_q;
    assign octave         = octave_q;
    assign status_valid   = st_valid_q;
    assign status_note_on = st_on_q;
    assign status_note    = st_note_q;
    assign status_octave  = st_oct_q;
    assign status_channel = st_ch_q;
    assign drop           = drop_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized bench for midi_voice_allocator against a voice-table model.
module tb_midi_voice_allocator;

    localparam int CH      = 3;
    localparam int AGE_SAT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [1:0]    req_note_on = '0;
    logic [7:0]    req_note = '0;
    logic [3:0]    req_octave = '0;
    logic [CH-1:0] voice_done = '0;
    logic [CH-1:0] key_on, key_off;
    logic [3:0]    note;
    logic [1:0]    octave;
    logic          status_valid, status_note_on;
    logic [3:0]    status_note;
    logic [1:0]    status_octave;
    logic [3:0]    status_channel;
    logic          drop;

    midi_voice_allocator #(.CHANNELS(CH), .AGE_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_note_on(req_note_on), .req_note(req_note),
        .req_octave(req_octave), .voice_done(voice_done),
        .key_on(key_on), .key_off(key_off),
        .note(note), .octave(octave),
        .status_valid(status_valid), .status_note_on(status_note_on),
        .status_note(status_note), .status_octave(status_octave),
        .status_channel(status_channel), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a table of voices plus the last values shown on the outputs.
    bit m_busy [CH];
    int m_note [CH];
    int m_oct  [CH];
    int m_age  [CH];
    int m_last;
    int h_note, h_oct, h_son, h_snote, h_soct, h_sch;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_busy[i] = 0; m_note[i] = 0; m_oct[i] = 0; m_age[i] = 0;
        end
        m_last = 1;
        h_note = 0; h_oct = 0; h_son = 0; h_snote = 0; h_soct = 0; h_sch = 0;
    endfunction

    function automatic int predict(input bit on, input int n, input int o);
        int best;
        for (int i = 0; i < CH; i++)
            if (m_busy[i] && m_note[i] == n && m_oct[i] == o) return i;
        if (!on) return -1;
        for (int i = 0; i < CH; i++)
            if (!m_busy[i]) return i;
`ifdef VOICE_STEAL_EN
        best = -1;
        for (int i = 0; i < CH; i++)
            if (m_busy[i] && m_age[i] > best) best = m_age[i];
        for (int i = 0; i < CH; i++)
            if (m_busy[i] && m_age[i] == best) return i;
`else
        best = 0;
`endif
        return -1 + best * 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rst_ready", req_ready, 2'b01);
        chk("rst_keyon", key_on, 0);
        chk("rst_keyoff", key_off, 0);
        chk("rst_stv", status_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_note", {note, octave}, 0);
    endtask

    // Entered and left at a negedge; one handshake plus LOOKUP and ISSUE.
    task automatic run_ev(input logic [1:0] v, input logic [1:0] on,
                          input logic [7:0] nt, input logic [3:0] oc,
                          input logic [CH-1:0] d_lk,
                          input logic [CH-1:0] d_is, input bit rst_lk);
        int g, tgt, en, eo;
        bit eon;
        logic [CH-1:0] ek_on, ek_off;
        req_valid = v; req_note_on = on; req_note = nt; req_octave = oc;
        if (v == 2'b11) g = (m_last == 1) ? 0 : 1;
        else if (v == 2'b10) g = 1;
        else g = 0;
        #1;
        chk("ready_idle", req_ready, (g == 1) ? 2'b10 : 2'b01);
        eon = on[g];
        en  = g ? int'(nt[7:4]) : int'(nt[3:0]);
        eo  = g ? int'(oc[3:2]) : int'(oc[1:0]);
        @(posedge clk);
        m_last = g;
        @(negedge clk);
        req_valid = '0; voice_done = d_lk; reset = rst_lk;
        chk("ready_lookup", req_ready, 0);
        chk("keyon_lookup", key_on, 0);
        tgt = predict(eon, en, eo);
        @(posedge clk);
        for (int i = 0; i < CH; i++) if (d_lk[i]) m_busy[i] = 0;
        if (rst_lk) model_reset();
        @(negedge clk);
        reset = 1'b0; voice_done = d_is;
        if (rst_lk) begin
            chk("rl_keyon", key_on, 0);
            chk("rl_stv", status_valid, 0);
            chk("rl_ready", req_ready, 2'b01);
            tgt = -1;
        end else begin
            ek_on = '0; ek_off = '0;
            if (tgt >= 0) begin
                if (eon) ek_on[tgt] = 1'b1; else ek_off[tgt] = 1'b1;
                h_note = en; h_oct = eo; h_son = eon;
                h_snote = en; h_soct = eo; h_sch = tgt;
            end
            chk("key_on", key_on, ek_on);
            chk("key_off", key_off, ek_off);
            chk("drop", drop, eon && tgt < 0);
            chk("st_valid", status_valid, tgt >= 0);
            chk("note_oct", {note, octave}, {h_note[3:0], h_oct[1:0]});
            chk("st_fields", {status_note_on, status_note, status_octave},
                {h_son[0], h_snote[3:0], h_soct[1:0]});
            chk("st_ch", status_channel, h_sch);
            chk("ready_issue", req_ready, 0);
        end
        @(posedge clk);
        if (!rst_lk && eon && tgt >= 0)
            for (int i = 0; i < CH; i++)
                if (i != tgt && m_busy[i])
                    m_age[i] = (m_age[i] < AGE_SAT) ? m_age[i] + 1 : AGE_SAT;
        for (int i = 0; i < CH; i++) if (d_is[i]) m_busy[i] = 0;
        if (tgt >= 0) begin
            if (eon) begin
                m_busy[tgt] = 1; m_note[tgt] = en; m_oct[tgt] = eo;
                m_age[tgt] = 0;
            end else begin
                m_busy[tgt] = 0;
            end
        end
        @(negedge clk);
        voice_done = '0;
    endtask

    task automatic spi_on(input int n, input int o, input logic [CH-1:0] d_is);
        run_ev(2'b01, 2'b01, 8'(n), 4'(o), '0, d_is, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        // basic note on
        spi_on(4, 1, '0);
        // tie arbitration
        do_reset();
        run_ev(2'b11, 2'b11, {4'd2, 4'd1}, 4'b0000, '0, '0, 0);
        run_ev(2'b10, 2'b11, {4'd2, 4'd1}, 4'b0000, '0, '0, 0);
        run_ev(2'b11, 2'b11, {4'd6, 4'd3}, 4'b0000, '0, '0, 0);
        // full table: steal or drop
        do_reset();
        spi_on(0, 0, '0); spi_on(1, 0, '0); spi_on(2, 0, '0);
        spi_on(7, 2, '0);
        // retrigger then new note
        do_reset();
        spi_on(5, 0, '0); spi_on(5, 0, '0); spi_on(9, 0, '0);
        // note off without and with a match
        do_reset();
        run_ev(2'b01, 2'b00, 8'd5, 4'd0, '0, '0, 0);
        spi_on(5, 0, '0);
        run_ev(2'b01, 2'b00, 8'd5, 4'd0, '0, '0, 0);
        // voice_done racing an allocation, then done during LOOKUP
        do_reset();
        spi_on(1, 0, '0);
        spi_on(2, 0, 3'b010);
        spi_on(3, 0, '0);
        spi_on(4, 0, '0);
        run_ev(2'b01, 2'b01, 8'd8, 4'd0, 3'b001, '0, 0);
        spi_on(10, 0, '0);
        // reset during LOOKUP
        run_ev(2'b01, 2'b01, 8'd11, 4'd1, '0, '0, 1);
        spi_on(12, 1, '0);
        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [1:0] v;
            logic [CH-1:0] dl, di;
            v  = 2'($urandom_range(1, 3));
            dl = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            di = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            run_ev(v, 2'($urandom),
                   {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                   {2'($urandom_range(0, 1)), 2'($urandom_range(0, 1))},
                   dl, di, 0);
            if ($urandom_range(0, 3) == 0) begin
                voice_done = ($urandom_range(0, 1) == 0) ? CH'($urandom) : '0;
                @(posedge clk);
                for (int i = 0; i < CH; i++) if (voice_done[i]) m_busy[i] = 0;
                @(negedge clk);
                voice_done = '0;
                chk("idle_keyon", key_on | key_off, 0);
            end
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
